rowbias_bank: RTL and testbench

Bank of `NUM_ROWS` independent row-bias shuffle pools. Each row holds a random permutation of the `WIDTH` one-hot values, built by an inside-out Fisher-Yates shuffle after reset. A one-hot index reads from the pool, and each row can be reshuffled on demand without disturbing the others. It sits between the solver's random source and the tile grid, supplying one value-to-try bus per grid row.

---
 rtl/rowbias_bank.sv | 108 ++++++++++
 tb/tb_rowbias_bank.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rowbias_bank.sv
// Bank of independent per-row shuffle pools. Each row builds a random permutation of the one-hot
// values with an inside-out Fisher-Yates shuffle and serves registered lookups by one-hot index.
`ifndef GRID_LEN
`define GRID_LEN 9
`endif

module rowbias_bank #(
  parameter int unsigned WIDTH      = `GRID_LEN,
  parameter int unsigned NUM_ROWS   = `GRID_LEN,
  parameter int unsigned RAND_WIDTH = 8,
  parameter int unsigned SHUFFLE_EN = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_ROWS*RAND_WIDTH-1:0] random,
  input  logic [NUM_ROWS-1:0]            reshuffle,
  input  logic [NUM_ROWS-1:0]            update,
  input  logic [NUM_ROWS*WIDTH-1:0]      rqindex,
  output logic [NUM_ROWS*WIDTH-1:0]      valtotry,
  output logic [NUM_ROWS-1:0]            ready
);

  localparam int unsigned KW = $clog2(WIDTH) + 1;
  // Wide enough that k+1 never overflows and the random word is never truncated.
  localparam int unsigned MW = ((RAND_WIDTH > KW) ? RAND_WIDTH : KW) + 1;

  typedef enum logic [1:0] {StInit, StShuffle, StReady} state_e;

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    state_e           st_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] pool_q [WIDTH];
    logic [WIDTH-1:0] pool_d [WIDTH];
    logic [WIDTH-1:0] val_q;
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] onehot_k;
    logic [WIDTH-1:0] pool_j;
    logic [MW-1:0]    rnd;
    logic [MW-1:0]    modulus;
    logic [KW-1:0]    j;
    logic             rdy_q;

    always_comb begin
      rnd      = MW'(random[r*RAND_WIDTH +: RAND_WIDTH]);
      modulus  = MW'(k_q) + MW'(1);
      j        = (SHUFFLE_EN != 0) ? KW'(rnd % modulus) : k_q;
      onehot_k = WIDTH'(1) << k_q;
      pool_j   = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (KW'(i) == j) pool_j = pool_q[i];
      end
      pool_d = pool_q;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (KW'(i) == k_q) begin
          pool_d[i] = (j == k_q) ? onehot_k : pool_j;
        end else if (KW'(i) == j) begin
          pool_d[i] = onehot_k;
        end
      end
    end

    // Descending scan so the lowest set index bit wins; only a ready pool is visible.
    always_comb begin
      rd_val = '0;
      if (st_q == StReady) begin
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
          if (rqindex[r*WIDTH + i]) rd_val = pool_q[i];
        end
      end
    end

    always_ff @(posedge clock) begin
      if (!reset) begin
        st_q  <= StInit;
        k_q   <= '0;
        val_q <= '0;
        rdy_q <= 1'b0;
      end else begin
        if (update[r]) val_q <= rd_val;
        unique case (st_q)
          StInit: begin
            k_q  <= '0;
            st_q <= StShuffle;
          end
          StShuffle: begin
            pool_q <= pool_d;
            k_q    <= k_q + KW'(1);
            if (k_q == KW'(WIDTH - 1)) begin
              st_q  <= StReady;
              rdy_q <= 1'b1;
            end
          end
          StReady: begin
            if (reshuffle[r]) begin
              st_q  <= StInit;
              rdy_q <= 1'b0;
            end
          end
          default: st_q <= StInit;
        endcase
      end
    end

    assign valtotry[r*WIDTH +: WIDTH] = val_q;
    assign ready[r]                   = rdy_q;
  end

endmodule

// File: tb/tb_rowbias_bank.sv
// Directed bench for rowbias_bank: fixed-random pools, identity pools, reshuffle isolation,
// mid-shuffle reset, and permutation/distribution of a 9-wide pool under random input.
module tb_rowbias_bank;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;
  int   checks = 0;
  int   errors = 0;

  // a: WIDTH 4, two rows, shuffling enabled
  logic [15:0] a_random;
  logic [1:0]  a_reshuffle, a_update, a_ready;
  logic [7:0]  a_rqindex, a_valtotry;
  // b: WIDTH 4, one row, shuffling disabled
  logic [7:0]  b_random;
  logic        b_reshuffle, b_update, b_ready;
  logic [3:0]  b_rqindex, b_valtotry;
  // c: WIDTH 9, one row, used for the permutation/distribution run
  logic [15:0] c_random;
  logic        c_reshuffle, c_update, c_ready;
  logic [8:0]  c_rqindex, c_valtotry;

  rowbias_bank #(.WIDTH(4), .NUM_ROWS(2), .RAND_WIDTH(8), .SHUFFLE_EN(1)) u_a (
    .clock(clock), .reset(reset), .random(a_random), .reshuffle(a_reshuffle),
    .update(a_update), .rqindex(a_rqindex), .valtotry(a_valtotry), .ready(a_ready)
  );

  rowbias_bank #(.WIDTH(4), .NUM_ROWS(1), .RAND_WIDTH(8), .SHUFFLE_EN(0)) u_b (
    .clock(clock), .reset(reset), .random(b_random), .reshuffle(b_reshuffle),
    .update(b_update), .rqindex(b_rqindex), .valtotry(b_valtotry), .ready(b_ready)
  );

  rowbias_bank #(.WIDTH(9), .NUM_ROWS(1), .RAND_WIDTH(16), .SHUFFLE_EN(1)) u_c (
    .clock(clock), .reset(reset), .random(c_random), .reshuffle(c_reshuffle),
    .update(c_update), .rqindex(c_rqindex), .valtotry(c_valtotry), .ready(c_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_c(input string tag);
    int n = 0;
    while (c_ready !== 1'b1 && n < 30) begin
      c_random = 16'($urandom);
      tick();
      n++;
    end
    chk(tag, 32'(c_ready), 32'd1);
  endtask

  localparam int NSHUF = 3000;

  logic [7:0] idx_t [4];
  logic [7:0] exp_t [4];
  int         hist [9];
  logic [8:0] v, v0, seen;
  logic       ok;

  initial begin
    idx_t = '{8'b0100_0001, 8'b0001_0010, 8'b1000_0100, 8'b0010_1000};
    exp_t = '{8'b0100_1000, 8'b0001_0001, 8'b1000_0010, 8'b0010_0100};
    for (int b = 0; b < 9; b++) hist[b] = 0;

    reset = 1'b0;
    a_random = '0; a_reshuffle = '0; a_update = '0; a_rqindex = '0;
    b_random = 8'h5a; b_reshuffle = 1'b0; b_update = 1'b0; b_rqindex = '0;
    c_random = '0; c_reshuffle = 1'b0; c_update = 1'b0; c_rqindex = '0;
    tick();
    tick();
    chk("rst_a_ready", 32'(a_ready), 32'd0);
    chk("rst_a_val", 32'(a_valtotry), 32'd0);
    chk("rst_b_ready", 32'(b_ready), 32'd0);
    chk("rst_b_val", 32'(b_valtotry), 32'd0);
    chk("rst_c_ready", 32'(c_ready), 32'd0);

    // Row 0 shuffles with random=0; row 1 gets random=k so j=k every step.
    reset = 1'b1;
    tick();
    chk("e0_ready", 32'(a_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      a_random[15:8] = 8'(k);
      b_random = 8'($urandom);
      if (k == 3) chk("e3_ready", 32'(a_ready), 32'd0);
      tick();
    end
    chk("e4_a_ready", 32'(a_ready), 32'b11);
    chk("e4_b_ready", 32'(b_ready), 32'd1);

    a_update = 2'b11;
    for (int s = 0; s < 4; s++) begin
      a_rqindex = idx_t[s];
      tick();
      chk($sformatf("a_read%0d", s), 32'(a_valtotry), 32'(exp_t[s]));
    end
    a_rqindex = 8'b0110_0000;
    tick();
    chk("a_zero_idx", 32'(a_valtotry), 32'b0010_0000);
    a_rqindex = 8'b0000_0110;
    tick();
    chk("a_multi_idx", 32'(a_valtotry), 32'b0000_0001);
    a_update = 2'b00;
    a_rqindex = 8'b1000_1000;
    tick();
    chk("a_hold", 32'(a_valtotry), 32'b0000_0001);
    a_update = 2'b10;
    tick();
    chk("a_upd_row1", 32'(a_valtotry), 32'b1000_0001);

    b_update = 1'b1;
    b_rqindex = 4'b0100;
    tick();
    chk("b_identity", 32'(b_valtotry), 32'b0100);
    b_rqindex = 4'b1010;
    b_random = 8'($urandom);
    tick();
    chk("b_multi_idx", 32'(b_valtotry), 32'b0010);

    // Reshuffle row 0 while row 1 reads continuously.
    a_random = '0;
    a_update = 2'b11;
    a_rqindex = 8'b0100_0001;
    a_reshuffle = 2'b01;
    tick();
    a_reshuffle = 2'b00;
    chk("rs0_ready", 32'(a_ready), 32'b10);
    chk("rs0_val", 32'(a_valtotry), 32'b0100_1000);
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk($sformatf("rs%0d_ready", c), 32'(a_ready), (c == 5) ? 32'b11 : 32'b10);
      chk($sformatf("rs%0d_val", c), 32'(a_valtotry), 32'b0100_0000);
      // A request mid-shuffle must be ignored.
      a_reshuffle = (c == 2) ? 2'b01 : 2'b00;
    end
    tick();
    chk("rs6_val", 32'(a_valtotry), 32'b0100_1000);
    chk("rs6_ready", 32'(a_ready), 32'b11);

    // Reset while row 0 sits at k=2.
    a_reshuffle = 2'b01;
    tick();
    a_reshuffle = 2'b00;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("mid_a_ready", 32'(a_ready), 32'd0);
    chk("mid_a_val", 32'(a_valtotry), 32'd0);
    chk("mid_b_ready", 32'(b_ready), 32'd0);
    chk("mid_b_val", 32'(b_valtotry), 32'd0);
    chk("mid_c_ready", 32'(c_ready), 32'd0);
    reset = 1'b1;
    tick();
    tick();
    tick();
    tick();
    chk("mid_e3_ready", 32'(a_ready), 32'd0);
    tick();
    chk("mid_e4_ready", 32'(a_ready), 32'b11);
    a_rqindex = 8'b0010_0001;
    tick();
    chk("mid_restart_val", 32'(a_valtotry), 32'b0001_1000);

    wait_c("c_ready_init");
    for (int n = 0; n < NSHUF; n++) begin
      c_reshuffle = 1'b1;
      c_random = 16'($urandom);
      tick();
      c_reshuffle = 1'b0;
      wait_c("c_ready");
      c_update = 1'b1;
      seen = '0;
      ok = 1'b1;
      v0 = '0;
      for (int i = 0; i < 9; i++) begin
        c_rqindex = 9'b1 << i;
        tick();
        v = c_valtotry;
        if (!$onehot(v)) ok = 1'b0;
        seen = seen | v;
        if (i == 0) v0 = v;
      end
      c_update = 1'b0;
      chk("c_perm", 32'({ok, seen}), 32'({1'b1, 9'h1ff}));
      for (int b = 0; b < 9; b++) if (v0[b]) hist[b]++;
    end
    for (int b = 0; b < 9; b++) begin
      chk($sformatf("c_hist%0d_n%0d", b, hist[b]),
          32'((45 * hist[b] >= 4 * NSHUF) && (15 * hist[b] <= 2 * NSHUF)), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
